// File: rtl/fifo_out_arb.sv
// Round-robin, packet-atomic scheduler for the 36-bit write port of the output FIFO.
// Tracks free FIFO words with a credit counter that is replenished by read-side CREDIT pulses.
module fifo_out_arb #(
    parameter int NREQ   = 4,
    parameter int DEPTH  = 1024,
    parameter int MAXPKT = 64
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NREQ-1:0]             REQ,
    input  logic [36*NREQ-1:0]          DI,
    input  logic [NREQ-1:0]             LAST,
    output logic [NREQ-1:0]             ACK,
    output logic [35:0]                 DO,
    output logic                        WREN,
    input  logic                        CREDIT,
    output logic [2:0]                  GNT,
    output logic                        BUSY,
    output logic [$clog2(DEPTH+1)-1:0]  CREDITS,
    output logic                        OVERFLOW
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [35:0]     do_q, do_d;
    logic            wren_q, wren_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic            ovf_q, ovf_d;

    logic            req_g_s;
    logic            last_g_s;
    logic [35:0]     di_g_s;
    logic            accept_s;
    logic [NREQ-1:0] ack_s;
    logic            hi_hit_s;
    logic [2:0]      hi_win_s;
    logic [2:0]      lo_win_s;
    logic [2:0]      winner_s;
    logic            any_req_s;
    logic            credits_ok_s;

    // Select the request, last flag and data word of the currently granted requester.
    always_comb begin
        req_g_s  = 1'b0;
        last_g_s = 1'b0;
        di_g_s   = 36'd0;
        for (int i = 0; i < NREQ; i++) begin
            req_g_s  = req_g_s  | (REQ[i]  & (gnt_q == 3'(i)));
            last_g_s = last_g_s | (LAST[i] & (gnt_q == 3'(i)));
            di_g_s   = di_g_s   | (DI[36*i +: 36] & {36{gnt_q == 3'(i)}});
        end
    end

    // Round-robin search: lowest index above the pointer first, otherwise wrap to the lowest index.
    always_comb begin
        hi_hit_s = 1'b0;
        hi_win_s = 3'd0;
        lo_win_s = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            hi_hit_s = hi_hit_s | (REQ[i] & (3'(i) > ptr_q));
            hi_win_s = (REQ[i] && (3'(i) > ptr_q)) ? 3'(i) : hi_win_s;
            lo_win_s = (REQ[i] && (3'(i) <= ptr_q)) ? 3'(i) : lo_win_s;
        end
        winner_s = hi_hit_s ? hi_win_s : lo_win_s;
    end

    assign any_req_s    = |REQ;
    assign credits_ok_s = (credits_q >= CW'(MAXPKT));
    assign accept_s     = (state_q == ST_XFER) && req_g_s && (credits_q != CW'(0));

    // One-hot acknowledge towards the granted requester only.
    always_comb begin
        ack_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            ack_s[i] = accept_s & (gnt_q == 3'(i));
        end
    end

    // Arbitration state machine and FIFO write path next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        do_d    = do_q;
        wren_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s && credits_ok_s) begin
                    state_d = ST_XFER;
                    gnt_d   = winner_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (accept_s) begin
                    wren_d = 1'b1;
                    do_d   = di_g_s;
                    // Finishing requester becomes lowest priority for the next grant.
                    if (last_g_s) begin
                        state_d = ST_IDLE;
                        ptr_d   = gnt_q;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    wren_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Credit counter: accept consumes, CREDIT returns, both together cancel out.
    always_comb begin
        credits_d = credits_q;
        ovf_d     = ovf_q;
        case ({accept_s, CREDIT})
            2'b10: begin
                credits_d = credits_q - CW'(1);
            end
            2'b01: begin
                if (credits_q == CW'(DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: begin
                credits_d = credits_q;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'(NREQ - 1);
            gnt_q     <= 3'd0;
            do_q      <= 36'd0;
            wren_q    <= 1'b0;
            credits_q <= CW'(DEPTH);
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            do_q      <= do_d;
            wren_q    <= wren_d;
            credits_q <= credits_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ACK      = ack_s;
    assign DO       = do_q;
    assign WREN     = wren_q;
    assign GNT      = gnt_q;
    assign BUSY     = (state_q == ST_XFER);
    assign CREDITS  = credits_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_fifo_out_arb.sv
// Self-checking bench for fifo_out_arb: cycle table for the first packet, then producer
// models with a write scoreboard and a credit model for arbitration and credit corner cases.
module tb_fifo_out_arb;

    localparam int NREQ   = 4;
    localparam int DEPTH  = 1024;
    localparam int MAXPKT = 64;
    localparam int CW     = 11;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      REQ;
    logic [36*NREQ-1:0]   DI;
    logic [NREQ-1:0]      LAST;
    logic [NREQ-1:0]      ACK;
    logic [35:0]          DO;
    logic                 WREN;
    logic                 CREDIT;
    logic [2:0]           GNT;
    logic                 BUSY;
    logic [CW-1:0]        CREDITS;
    logic                 OVERFLOW;

    fifo_out_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .MAXPKT(MAXPKT)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DI(DI), .LAST(LAST), .ACK(ACK),
        .DO(DO), .WREN(WREN), .CREDIT(CREDIT), .GNT(GNT), .BUSY(BUSY),
        .CREDITS(CREDITS), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    int          npk[NREQ];
    int          plen[NREQ];
    int          sent[NREQ];
    bit          en[NREQ];
    int          exp_cred;
    logic        exp_ovf;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [35:0]     di;
        logic            last;
        logic [NREQ-1:0] ack;
        logic            wren;
        logic [35:0]     dout;
        logic            busy;
        int              cred;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        DI = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && sent[i] < npk[i] * plen[i]) begin
                REQ[i]         = 1'b1;
                DI[36*i +: 36] = {4'(i), 32'(sent[i])};
                LAST[i]        = ((sent[i] % plen[i]) == plen[i] - 1);
            end else begin
                REQ[i]  = 1'b0;
                LAST[i] = 1'b0;
            end
        end
    endtask

    task automatic push_exp(input int r, input int first, input int n);
        for (int w = 0; w < n; w++) exp_q.push_back({4'(r), 32'(first + w)});
    endtask

    task automatic cycle();
        logic [NREQ-1:0] ack;
        logic [35:0]     e;
        logic            crd;
        @(negedge CLK);
        ack = ACK;
        crd = CREDIT;
        chk("ack_onehot", 64'($countones(ack) <= 1), 1);
        chk("ack_only_requesting", 64'((ack & ~REQ) == 0), 1);
        chk("credits_model", CREDITS, exp_cred);
        chk("overflow_model", OVERFLOW, exp_ovf);
        if (WREN) begin
            chk("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("do_word", DO, e);
            end
        end
        @(posedge CLK);
        #1;
        if (ack != 0 && !crd) exp_cred--;
        else if (crd && ack == 0) begin
            if (exp_cred == DEPTH) exp_ovf = 1'b1;
            else exp_cred++;
        end
        for (int i = 0; i < NREQ; i++) if (ack[i]) sent[i]++;
        drive_inputs();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_idle"}, BUSY, 0);
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        REQ    = '0;
        LAST   = '0;
        DI     = '0;
        CREDIT = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            npk[i]  = 0;
            plen[i] = 1;
            sent[i] = 0;
            en[i]   = 1'b1;
        end
        exp_q.delete();
        exp_cred = DEPTH;
        exp_ovf  = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{4'b0001, 36'd1, 1'b0, 4'b0000, 1'b0, 36'd0, 1'b0, 1024};
        tbl[1] = '{4'b0001, 36'd1, 1'b0, 4'b0001, 1'b0, 36'd0, 1'b1, 1024};
        tbl[2] = '{4'b0001, 36'd2, 1'b0, 4'b0001, 1'b1, 36'd1, 1'b1, 1023};
        tbl[3] = '{4'b0001, 36'd3, 1'b0, 4'b0001, 1'b1, 36'd2, 1'b1, 1022};
        tbl[4] = '{4'b0001, 36'd4, 1'b1, 4'b0001, 1'b1, 36'd3, 1'b1, 1021};
        tbl[5] = '{4'b0000, 36'd0, 1'b0, 4'b0000, 1'b1, 36'd4, 1'b0, 1020};
        tbl[6] = '{4'b0000, 36'd0, 1'b0, 4'b0000, 1'b0, 36'd4, 1'b0, 1020};

        // Reset state and single 4-word packet, cycle by cycle.
        do_reset();
        chk("rst_wren", WREN, 0);
        chk("rst_do", DO, 0);
        chk("rst_gnt", GNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_credits", CREDITS, 1024);
        chk("rst_overflow", OVERFLOW, 0);
        for (int k = 0; k < 7; k++) begin
            REQ      = tbl[k].req;
            DI       = '0;
            DI[35:0] = tbl[k].di;
            LAST     = {3'b000, tbl[k].last};
            @(negedge CLK);
            chk($sformatf("t1_ack[%0d]", k), ACK, tbl[k].ack);
            chk($sformatf("t1_wren[%0d]", k), WREN, tbl[k].wren);
            if (tbl[k].wren) chk($sformatf("t1_do[%0d]", k), DO, tbl[k].dout);
            chk($sformatf("t1_busy[%0d]", k), BUSY, tbl[k].busy);
            chk($sformatf("t1_gnt[%0d]", k), GNT, 0);
            chk($sformatf("t1_credits[%0d]", k), CREDITS, 64'(tbl[k].cred));
            @(posedge CLK);
            #1;
        end

        // All four requesters with 2-word packets: order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            npk[i]  = 2;
            plen[i] = 2;
        end
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NREQ; i++) push_exp(i, 2 * p, 2);
        drive_inputs();
        run_until_idle("t2", 60);
        chk("t2_credits", CREDITS, 1008);

        // Credit gating at 63 free words, released by one CREDIT pulse.
        do_reset();
        npk[0]  = 1;
        plen[0] = 961;
        push_exp(0, 0, 961);
        drive_inputs();
        run_until_idle("t3_fill", 1100);
        chk("t3_credits63", CREDITS, 63);
        npk[1]  = 1;
        plen[1] = 1;
        push_exp(1, 0, 1);
        drive_inputs();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_no_grant", BUSY, 0);
        end
        CREDIT = 1'b1;
        cycle();
        CREDIT = 1'b0;
        chk("t3_credits64", CREDITS, 64);
        chk("t3_not_yet", BUSY, 0);
        cycle();
        chk("t3_granted", BUSY, 1);
        chk("t3_gnt", GNT, 1);
        run_until_idle("t3", 10);

        // Mid-packet stall of requester 0 while requester 2 waits.
        do_reset();
        npk[0]  = 1;
        plen[0] = 4;
        npk[2]  = 1;
        plen[2] = 2;
        push_exp(0, 0, 4);
        push_exp(2, 0, 2);
        drive_inputs();
        n = 0;
        while (sent[0] < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("t4_started", sent[0], 2);
        en[0] = 1'b0;
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_stall_ack", ACK, 0);
            chk("t4_stall_gnt", GNT, 0);
            chk("t4_stall_busy", BUSY, 1);
            if (k > 0) chk("t4_stall_wren", WREN, 0);
            cycle();
        end
        en[0] = 1'b1;
        drive_inputs();
        #1;
        chk("t4_resume_wren", WREN, 0);
        chk("t4_resume_ack", ACK, 4'b0001);
        run_until_idle("t4", 30);

        // Credit exhaustion, simultaneous accept+CREDIT, overflow.
        do_reset();
        npk[0]  = 1;
        plen[0] = 960;
        push_exp(0, 0, 960);
        drive_inputs();
        run_until_idle("t5_fill", 1100);
        chk("t5_credits64", CREDITS, 64);
        npk[1]  = 1;
        plen[1] = 100;
        push_exp(1, 0, 100);
        drive_inputs();
        n = 0;
        while (sent[1] < 64 && n < 200) begin
            cycle();
            n++;
        end
        for (int k = 0; k < 3; k++) cycle();
        chk("t5_stalled_sent", sent[1], 64);
        chk("t5_credits0", CREDITS, 0);
        chk("t5_stalled_busy", BUSY, 1);
        for (int k = 0; k < 35; k++) begin
            CREDIT = 1'b1;
            cycle();
            CREDIT = 1'b0;
            cycle();
            chk("t5_one_per_credit", sent[1], 65 + k);
        end
        CREDIT = 1'b1;
        cycle();
        cycle();
        CREDIT = 1'b0;
        chk("t5_last_sent", sent[1], 100);
        chk("t5_simultaneous", CREDITS, 1);
        run_until_idle("t5", 10);
        CREDIT = 1'b1;
        for (int k = 0; k < 1023; k++) cycle();
        chk("t5_full", CREDITS, 1024);
        chk("t5_no_ovf_yet", OVERFLOW, 0);
        cycle();
        CREDIT = 1'b0;
        chk("t5_ovf", OVERFLOW, 1);
        chk("t5_saturated", CREDITS, 1024);

        // Asynchronous reset mid-packet; next grant must be requester 0.
        npk[0]  = 1;
        plen[0] = 8;
        sent[0] = 0;
        push_exp(0, 0, 8);
        drive_inputs();
        n = 0;
        while (sent[0] < 3 && n < 20) begin
            cycle();
            n++;
        end
        chk("t6_midpkt_busy", BUSY, 1);
        #1;
        RST = 1'b1;
        #1;
        chk("t6_wren", WREN, 0);
        chk("t6_ack", ACK, 0);
        chk("t6_busy", BUSY, 0);
        chk("t6_credits", CREDITS, 1024);
        chk("t6_overflow", OVERFLOW, 0);
        do_reset();
        npk[0]  = 1;
        plen[0] = 2;
        npk[2]  = 1;
        plen[2] = 2;
        push_exp(0, 0, 2);
        push_exp(2, 0, 2);
        drive_inputs();
        n = 0;
        while (!BUSY && n < 5) begin
            cycle();
            n++;
        end
        chk("t6_regrant_busy", BUSY, 1);
        chk("t6_regrant_gnt", GNT, 0);
        run_until_idle("t6", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
